hid_key_events: RTL and testbench
=================================

Name: hid_key_events

Overview:
- Sits directly downstream of usb_hid_host, in the same USB clock domain. It consumes the keyboard report outputs: typ, report, key_modifiers, key1..key4.
- Compares each new keyboard report with the previous one and emits discrete make/break events, one HID usage code per event.
- Events are buffered in a small show-ahead FIFO with a valid/ready interface. Consumers are a UART printer, a PS/2 or ASCII translator, or a soft CPU.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- KBD_TYP, 2'd1, usb_hid_host typ value that identifies a keyboard.

Ports:
- clk  in  1  USB core clock, the same clock that drives usb_hid_host.
- reset  in  1  synchronous, active-high reset.
- usb_type  in  2  typ output from usb_hid_host.
- usb_report  in  1  one-cycle strobe: a new report is valid on this cycle.
- key_modifiers  in  8  modifier bitmap (bit i corresponds to usage 0xE0+i).
- key1, key2, key3, key4  in  8 each  pressed usage codes; 0x00 means empty slot.
- ev_valid  out  1  the FIFO head holds an event.
- ev_ready  in  1  the consumer accepts the head this cycle.
- ev_code  out  8  usage code of the head event.
- ev_make  out  1  1 = press, 0 = release.
- ev_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- report_lost  out  1  sticky: a pending report was overwritten before it was scanned.
- busy  out  1  the scan FSM is not in IDLE.

Behaviour:
- Reset values:
  - All outputs 0; FIFO empty.
  - Previous-state registers (prev_mod, prev_k[1:4]) all 0.
  - Pending buffer empty; FSM in IDLE.
- Report capture:
  - On usb_report with usb_type==KBD_TYP, the 40-bit report {mod, k1..k4} is latched into the pending buffer.
  - A capture arriving while pending is already full overwrites it and sets report_lost.
- Error-report filter: if any of key1..4 is in the range 0x01..0x03 (rollover/POST fail), the report is discarded. It is not latched, and nothing changes.
- Disconnect: when usb_type changes from KBD_TYP to any other value, an all-zero report is injected into the pending buffer. This releases every held key. Overwrite rules are the same as for a captured report.
- FSM states: IDLE, MOD, BRK, MAK, COMMIT.
  - IDLE: if pending is full, move it into a working register, clear pending, and go to MOD with idx=0.
  - MOD (8 cycles, idx 0..7): if new_mod[idx] != prev_mod[idx], emit code 0xE0+idx with make=new_mod[idx].
  - BRK (4 cycles, idx 0..3): if prev_k[idx]!=0 and prev_k[idx] is not equal to any new_k, emit prev_k[idx] with make=0.
  - MAK (4 cycles, idx 0..3): if new_k[idx]!=0 and new_k[idx] is not equal to any prev_k, emit new_k[idx] with make=1.
  - COMMIT (1 cycle): prev <= working; return to IDLE.
  - A scan takes exactly 18 cycles including IDLE. busy is 1 in MOD, BRK, MAK and COMMIT.
  - Duplicate nonzero codes in the same report each produce their own event. Slot order changes alone produce no event.
- Emission:
  - At most one push per cycle.
  - If the FIFO is full and no pop occurs that cycle, the event is dropped, overflow is set, and the scan continues.
  - prev is always committed, even when events were dropped.
- Latency: usb_report sampled at edge T; if the first MOD step emits, ev_valid=1 after edge T+2.
- FIFO:
  - Show-ahead: ev_code and ev_make are valid whenever ev_valid=1. A pop happens when ev_valid && ev_ready.
  - A pop and a push in the same cycle while full are both accepted; ev_count stays at DEPTH.
  - There is no bypass: with the FIFO empty, a push is visible on the next cycle.
  - Pointers wrap modulo DEPTH.
- Sticky flags clear only on reset.
- Reset asserted mid-scan: the FSM returns to IDLE, the FIFO and prev are cleared, and the pending buffer is discarded.

Test Plan:
- Press A: report mod=0, k1=0x04 after reset -> exactly one event {0x04, make=1}; ev_count=1; busy for 17 cycles.
- Release with modifier: prev {0x00, 0x04}, new {mod=0x02, k=0} -> events in order {0xE1, 1} then {0x04, 0}.
- Slot reorder: prev k1=0x04, k2=0x05; new k1=0x05, k2=0x04 -> no events; prev updated.
- Rollover: report with k1..4=0x01 while 0x04 is held -> no events, prev unchanged, busy stays 0.
- Overflow: DEPTH=8, ev_ready=0, report mod=0xFF with k1..4=0x04..0x07 (12 makes) -> first 8 queued (0xE0..0xE7), overflow=1, ev_count=8. A later release of all keys with ev_ready=1 continuously yields 12 breaks.
- Disconnect/overwrite: hold 0x04, 0x05, then usb_type goes 1->0 -> breaks for 0x04 and 0x05. Two reports 2 cycles apart during a scan -> report_lost=1, only the second is scanned.

Source files
------------

// File: rtl/hid_key_events.sv
// Turns successive usb_hid_host keyboard reports into make/break events, one
// HID usage code per event, queued in a show-ahead FIFO with valid/ready.
module hid_key_events #(
  parameter int unsigned DEPTH   = 8,
  parameter logic [1:0]  KBD_TYP = 2'd1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               usb_type,
  input  logic                     usb_report,
  input  logic [7:0]               key_modifiers,
  input  logic [7:0]               key1,
  input  logic [7:0]               key2,
  input  logic [7:0]               key3,
  input  logic [7:0]               key4,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [7:0]               ev_code,
  output logic                     ev_make,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow,
  output logic                     report_lost,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {IDLE, MOD, BRK, MAK, COMMIT} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [1:0]  type_q;
  logic        pend_full;
  logic [39:0] pend;
  logic [7:0]  prev_mod, work_mod;
  logic [7:0]  prev_k [4];
  logic [7:0]  work_k [4];

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic        err_report, capture, disconnect, load, take;
  logic [39:0] load_data;
  logic        emit, emit_make, brk_hit, mak_hit;
  logic [7:0]  emit_code;
  logic        full, pop, push, drop;

  always_comb begin
    err_report = 1'b0;
    if (key1 != 8'h00 && key1 <= 8'h03) err_report = 1'b1;
    if (key2 != 8'h00 && key2 <= 8'h03) err_report = 1'b1;
    if (key3 != 8'h00 && key3 <= 8'h03) err_report = 1'b1;
    if (key4 != 8'h00 && key4 <= 8'h03) err_report = 1'b1;
  end

  assign capture    = usb_report && (usb_type == KBD_TYP) && !err_report;
  assign disconnect = (type_q == KBD_TYP) && (usb_type != KBD_TYP);
  assign load       = capture || disconnect;
  assign load_data  = capture ? {key_modifiers, key1, key2, key3, key4} : '0;
  assign take       = (state == IDLE) && pend_full;

  // A key is only a break/make if its code is absent from the other report,
  // so pure slot reordering yields nothing.
  always_comb begin
    emit      = 1'b0;
    emit_make = 1'b0;
    emit_code = '0;
    brk_hit   = 1'b0;
    mak_hit   = 1'b0;
    for (int unsigned j = 0; j < 4; j++) begin
      if (prev_k[idx[1:0]] == work_k[j]) brk_hit = 1'b1;
      if (work_k[idx[1:0]] == prev_k[j]) mak_hit = 1'b1;
    end
    case (state)
      MOD: if (work_mod[idx] != prev_mod[idx]) begin
        emit      = 1'b1;
        emit_code = 8'hE0 + {5'd0, idx};
        emit_make = work_mod[idx];
      end
      BRK: if (prev_k[idx[1:0]] != 8'h00 && !brk_hit) begin
        emit      = 1'b1;
        emit_code = prev_k[idx[1:0]];
      end
      MAK: if (work_k[idx[1:0]] != 8'h00 && !mak_hit) begin
        emit      = 1'b1;
        emit_code = work_k[idx[1:0]];
        emit_make = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      type_q      <= '0;
      pend_full   <= 1'b0;
      pend        <= '0;
      report_lost <= 1'b0;
      prev_mod    <= '0;
      work_mod    <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        prev_k[i] <= '0;
        work_k[i] <= '0;
      end
    end else begin
      type_q <= usb_type;
      // A load in the same cycle IDLE takes the buffer is not a loss.
      if (load) begin
        pend      <= load_data;
        pend_full <= 1'b1;
        if (pend_full && !take) report_lost <= 1'b1;
      end else if (take) begin
        pend_full <= 1'b0;
      end

      case (state)
        IDLE: if (pend_full) begin
          work_mod  <= pend[39:32];
          work_k[0] <= pend[31:24];
          work_k[1] <= pend[23:16];
          work_k[2] <= pend[15:8];
          work_k[3] <= pend[7:0];
          idx       <= '0;
          state     <= MOD;
          busy      <= 1'b1;
        end
        MOD: begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) state <= BRK;
        end
        BRK: begin
          idx <= (idx == 3'd3) ? 3'd0 : idx + 3'd1;
          if (idx == 3'd3) state <= MAK;
        end
        MAK: begin
          idx <= (idx == 3'd3) ? 3'd0 : idx + 3'd1;
          if (idx == 3'd3) state <= COMMIT;
        end
        COMMIT: begin
          prev_mod <= work_mod;
          for (int unsigned i = 0; i < 4; i++) prev_k[i] <= work_k[i];
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ev_valid = (ev_count != '0);
  assign ev_code  = mem[rd_ptr][7:0];
  assign ev_make  = mem[rd_ptr][8];
  assign full     = (ev_count == CW'(DEPTH));
  assign pop      = ev_valid && ev_ready;
  assign push     = emit && (!full || pop);
  assign drop     = emit && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {emit_make, emit_code};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   ev_count <= ev_count + CW'(1);
        2'b01:   ev_count <= ev_count - CW'(1);
        default: ev_count <= ev_count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hid_key_events.sv
// Self-checking bench for hid_key_events: vector table, hand-written corner
// sequences and random reports checked against a set-difference key model.
module tb_hid_key_events;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] usb_type = 2'd1;
  logic       usb_report = 1'b0;
  logic [7:0] key_modifiers = '0, key1 = '0, key2 = '0, key3 = '0, key4 = '0;
  logic       ev_valid, ev_ready = 1'b0, ev_make, overflow, report_lost, busy;
  logic [7:0] ev_code;
  logic [$clog2(DEPTH):0] ev_count;

  always #5 clk = ~clk;

  hid_key_events #(.DEPTH(DEPTH), .KBD_TYP(2'd1)) dut (
    .clk(clk), .reset(reset), .usb_type(usb_type), .usb_report(usb_report),
    .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3),
    .key4(key4), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_make(ev_make), .ev_count(ev_count), .overflow(overflow),
    .report_lost(report_lost), .busy(busy)
  );

  int unsigned total = 0, passed = 0;
  logic [8:0]  got_q[$];
  logic [8:0]  exp_q[$];
  logic [7:0]  m_mod;
  logic [31:0] m_keys;

  // {make, code} of every accepted pop
  always @(negedge clk)
    if (!reset && ev_valid && ev_ready) got_q.push_back({ev_make, ev_code});

  typedef struct packed {
    logic [7:0]  mod;
    logic [31:0] keys;
    logic        filt;
    logic [2:0]  n;
    logic [53:0] evs;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] key_at(input logic [31:0] s, input int i);
    return 8'(s >> (24 - 8 * i));
  endfunction

  function automatic bit in_set(input logic [7:0] c, input logic [31:0] s);
    for (int i = 0; i < 4; i++) if (key_at(s, i) == c) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: modifier toggles, then codes leaving the set, then codes joining it.
  task automatic model_apply(input logic [7:0] mod, input logic [31:0] keys);
    for (int i = 0; i < 4; i++)
      if (key_at(keys, i) >= 8'h01 && key_at(keys, i) <= 8'h03) return;
    for (int b = 0; b < 8; b++)
      if (mod[b] != m_mod[b]) exp_q.push_back({mod[b], 8'hE0 + 8'(b)});
    for (int i = 0; i < 4; i++)
      if (key_at(m_keys, i) != 8'h00 && !in_set(key_at(m_keys, i), keys))
        exp_q.push_back({1'b0, key_at(m_keys, i)});
    for (int i = 0; i < 4; i++)
      if (key_at(keys, i) != 8'h00 && !in_set(key_at(keys, i), m_keys))
        exp_q.push_back({1'b1, key_at(keys, i)});
    m_mod  = mod;
    m_keys = keys;
  endtask

  task automatic send_report(input logic [7:0] mod, input logic [31:0] keys);
    key_modifiers = mod;
    {key1, key2, key3, key4} = keys;
    usb_report = 1'b1;
    tick();
    usb_report = 1'b0;
  endtask

  task automatic wait_scan();
    int n = 0;
    do begin tick(); n++; end while (busy && n < 60);
    check("scan_done", busy, 0);
    repeat (10) tick();
  endtask

  task automatic compare_events(input string name);
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) check(name, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    usb_report = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    m_mod = '0;
    m_keys = '0;
    got_q.delete();
    exp_q.delete();
  endtask

  vec_t tbl[8];

  initial begin
    int n;
    logic [7:0]  rmod;
    logic [31:0] rkeys;

    tbl[0] = {8'h00, 32'h04000000, 1'b0, 3'd1, {9'h104, 45'h0}};
    tbl[1] = {8'h02, 32'h00000000, 1'b0, 3'd2, {9'h1E1, 9'h004, 36'h0}};
    tbl[2] = {8'h00, 32'h04050000, 1'b0, 3'd3, {9'h0E1, 9'h104, 9'h105, 27'h0}};
    tbl[3] = {8'h00, 32'h05040000, 1'b0, 3'd0, 54'h0};
    tbl[4] = {8'h00, 32'h01010101, 1'b1, 3'd0, 54'h0};
    tbl[5] = {8'h00, 32'h05000606, 1'b0, 3'd3, {9'h004, 9'h106, 9'h106, 27'h0}};
    tbl[6] = {8'h11, 32'h00000000, 1'b0, 3'd5,
              {9'h1E0, 9'h1E4, 9'h005, 9'h006, 9'h006, 9'h0}};
    tbl[7] = {8'h00, 32'h00000000, 1'b0, 3'd2, {9'h0E0, 9'h0E4, 36'h0}};

    do_reset();
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_count", ev_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_report_lost", report_lost, 0);
    check("rst_busy", busy, 0);
    check("rst_ev_code", {ev_make, ev_code}, 0);

    // Press A with the consumer stalled: one event, 17 busy cycles.
    send_report(8'h00, 32'h04000000);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) break;
      n++;
    end
    check("pressA_busy_cycles", n, 17);
    check("pressA_count", ev_count, 1);
    check("pressA_head", {ev_valid, ev_make, ev_code}, {1'b1, 1'b1, 8'h04});
    do_reset();

    // First MOD step emits: visible two edges after the report strobe.
    send_report(8'h01, 32'h04000000);
    check("lat_t0_valid", ev_valid, 0);
    tick();
    check("lat_t1_valid", ev_valid, 0);
    check("lat_t1_busy", busy, 1);
    tick();
    check("lat_t2_head", {ev_valid, ev_make, ev_code}, {1'b1, 1'b1, 8'hE0});
    do_reset();

    ev_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      send_report(tbl[r].mod, tbl[r].keys);
      tick();
      check($sformatf("tbl%0d_busy", r), busy, !tbl[r].filt);
      wait_scan();
      check($sformatf("tbl%0d_count", r), got_q.size(), tbl[r].n);
      for (int j = 0; j < int'(tbl[r].n) && j < got_q.size(); j++)
        check($sformatf("tbl%0d_ev%0d", r, j), got_q[j], 9'(tbl[r].evs >> (45 - 9 * j)));
      model_apply(tbl[r].mod, tbl[r].keys);
      got_q.delete();
      exp_q.delete();
    end

    for (int r = 0; r < 40; r++) begin
      int v;
      rmod = ($urandom_range(0, 2) == 0) ? 8'($urandom) : m_mod;
      for (int i = 0; i < 4; i++) begin
        v = $urandom_range(0, 9);
        rkeys = rkeys << 8;
        if (v <= 2) rkeys[7:0] = 8'h00;
        else if (v <= 8) rkeys[7:0] = 8'h04 + 8'(v - 3);
        else rkeys[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'h04;
      end
      model_apply(rmod, rkeys);
      send_report(rmod, rkeys);
      wait_scan();
      compare_events("rand");
    end
    check("rand_no_overflow", overflow, 0);
    check("rand_no_lost", report_lost, 0);

    // Overflow: 12 makes into 8 entries, then a full release drained live.
    do_reset();
    ev_ready = 1'b0;
    send_report(8'hFF, 32'h04050607);
    wait_scan();
    check("ovf_count", ev_count, DEPTH);
    check("ovf_flag", overflow, 1);
    check("ovf_head", {ev_valid, ev_make, ev_code}, {1'b1, 1'b1, 8'hE0});
    ev_ready = 1'b1;
    send_report(8'h00, 32'h00000000);
    wait_scan();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 8'hE0 + 8'(i)});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 8'hE0 + 8'(i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h04 + 8'(i)});
    compare_events("ovf_drain");
    check("ovf_sticky", overflow, 1);
    check("ovf_empty", ev_count, 0);

    // Disconnect releases held keys; non-keyboard reports are ignored.
    do_reset();
    model_apply(8'h00, 32'h04050000);
    send_report(8'h00, 32'h04050000);
    wait_scan();
    compare_events("hold");
    usb_type = 2'd0;
    tick();
    model_apply(8'h00, 32'h00000000);
    wait_scan();
    compare_events("disconnect");
    send_report(8'h00, 32'h04000000);
    tick();
    check("nonkbd_busy", busy, 0);
    wait_scan();
    compare_events("nonkbd");
    usb_type = 2'd1;

    // Two reports two cycles apart during a scan: only the second survives.
    do_reset();
    send_report(8'h00, 32'h04000000);
    repeat (3) tick();
    send_report(8'h00, 32'h05000000);
    check("lost_before", report_lost, 0);
    tick();
    send_report(8'h00, 32'h06000000);
    check("lost_after", report_lost, 1);
    repeat (60) tick();
    model_apply(8'h00, 32'h04000000);
    model_apply(8'h00, 32'h06000000);
    compare_events("overwrite");

    // Reset mid-scan clears FIFO, prev and the pending report.
    do_reset();
    ev_ready = 1'b0;
    send_report(8'h01, 32'h04000000);
    repeat (4) tick();
    send_report(8'h00, 32'h05000000);
    check("mid_busy", busy, 1);
    check("mid_count", ev_count, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", {ev_valid, ev_count}, 0);
    repeat (5) tick();
    check("mid_pend_dropped", busy, 0);
    got_q.delete();
    ev_ready = 1'b1;
    m_mod = '0;
    m_keys = '0;
    model_apply(8'h00, 32'h04000000);
    send_report(8'h00, 32'h04000000);
    wait_scan();
    compare_events("after_mid_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
